// File: rtl/chord_pkg.sv
`default_nettype none
// ============================================================================
//  chord_pkg : shared fixed-point widths, CORDIC constants and round/saturate
//  Revision  : 1.0
// ============================================================================
package chord_pkg;

   localparam int ITERATION_WORD_WIDTH      = 32;
   localparam int ITERATION_WORD_FRAC_WIDTH = 20;
   localparam int OUTPUT_WIDTH              = 16;
   localparam int OUTPUT_FRAC_WIDTH         = 8;
   localparam int SECTOR_FLAG_WIDTH         = 2;
   localparam int GAIN_WIDTH                = 16;

   localparam logic [GAIN_WIDTH-1:0] K_GAIN = 16'd39797;

   localparam logic signed [ITERATION_WORD_WIDTH-1:0] OFFSET_PI_2     = 32'sd1647099;
   localparam logic signed [ITERATION_WORD_WIDTH-1:0] OFFSET_PI       = 32'sd3294199;
   localparam logic signed [ITERATION_WORD_WIDTH-1:0] OFFSET_NEG_PI_2 = -32'sd1647099;

   typedef enum logic [SECTOR_FLAG_WIDTH-1:0] {
      SECTOR_0   = 2'd0,
      SECTOR_90  = 2'd1,
      SECTOR_180 = 2'd2,
      SECTOR_270 = 2'd3
   } sector_e;

   localparam int ANG_WIDTH = ITERATION_WORD_WIDTH + 1;
   localparam int SUM_WIDTH = ANG_WIDTH + 1;
   localparam int RND_SHIFT = ITERATION_WORD_FRAC_WIDTH - OUTPUT_FRAC_WIDTH;

   localparam logic signed [SUM_WIDTH-1:0] RND_HALF = SUM_WIDTH'(2 ** (RND_SHIFT - 1));
   localparam logic signed [SUM_WIDTH-1:0] SAT_MAX  = SUM_WIDTH'(2 ** (OUTPUT_WIDTH - 1) - 1);
   localparam logic signed [SUM_WIDTH-1:0] SAT_MIN  = SUM_WIDTH'(-(2 ** (OUTPUT_WIDTH - 1)));

   typedef struct packed {
      logic                           sat;
      logic signed [OUTPUT_WIDTH-1:0] value;
   } rs_t;

   // Round half up from Q11.20 to Q7.8, then clamp to the output range.
   function automatic rs_t round_sat(input logic signed [ANG_WIDTH-1:0] v);
      logic signed [SUM_WIDTH-1:0] sum;
      logic signed [SUM_WIDTH-1:0] shifted;
      rs_t r;
      sum     = {v[ANG_WIDTH-1], v} + RND_HALF;
      shifted = sum >>> RND_SHIFT;
      if (shifted > SAT_MAX) begin
         r.sat   = 1'b1;
         r.value = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      end else if (shifted < SAT_MIN) begin
         r.sat   = 1'b1;
         r.value = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
      end else begin
         r.sat   = 1'b0;
         r.value = shifted[OUTPUT_WIDTH-1:0];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  sync_fifo : show-ahead synchronous FIFO with full/empty/count status
//  Revision  : 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_pop, do_push;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the head slot, so a push at full is accepted in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/interface_output.sv
`default_nettype none
// ============================================================================
//  interface_output : CORDIC gain/quadrant correction, Q7.8 round/saturate,
//                     output FIFO with sticky overflow on drop
//  Revision         : 1.0
// ============================================================================
module interface_output
   import chord_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic signed [ITERATION_WORD_WIDTH-1:0] in_x,
   input  logic signed [ITERATION_WORD_WIDTH-1:0] in_z,
   input  logic [SECTOR_FLAG_WIDTH-1:0]           in_sector,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [OUTPUT_WIDTH-1:0]                out_mag,
   output logic [OUTPUT_WIDTH-1:0]                out_angle,
   output logic                                   out_sat,
   output logic                                   overflow
);

   localparam int IW = ITERATION_WORD_WIDTH;
   localparam int GW = GAIN_WIDTH;
   localparam int PW = 2 * OUTPUT_WIDTH + 1;

   logic signed [IW+GW:0]    prod;
   logic signed [IW-1:0]     offset;
   logic signed [IW-1:0]     s1_mag_d,  s1_mag_q;
   logic signed [ANG_WIDTH-1:0] s1_ang_d, s1_ang_q;
   logic                     s1_valid_q, s2_valid_q;
   logic [PW-1:0]            s2_payload_d, s2_payload_q;
   rs_t                      rs_mag, rs_ang;
   logic                     overflow_d, overflow_q;
   logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [PW-1:0]            fifo_rdata;
   logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
   logic                     prod_unused;

   // K is unsigned Q0.16; a zero sign bit keeps the product signed.
   assign prod     = in_x * $signed({1'b0, K_GAIN});
   assign s1_mag_d = prod[IW+GW-1:GW];
   assign prod_unused = ^{prod[IW+GW], prod[GW-1:0], fifo_count_unused};

   always_comb begin
      offset = '0;
      case (sector_e'(in_sector))
         SECTOR_90:  offset = OFFSET_PI_2;
         SECTOR_180: offset = OFFSET_PI;
         SECTOR_270: offset = OFFSET_NEG_PI_2;
         default:    offset = '0;
      endcase
   end

   assign s1_ang_d = {in_z[IW-1], in_z} + {offset[IW-1], offset};

   assign rs_mag       = round_sat({s1_mag_q[IW-1], s1_mag_q});
   assign rs_ang       = round_sat(s1_ang_q);
   assign s2_payload_d = {rs_mag.sat | rs_ang.sat, rs_ang.value, rs_mag.value};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_mag_q     <= '0;
         s1_ang_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_payload_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         s1_valid_q   <= in_valid;
         s1_mag_q     <= s1_mag_d;
         s1_ang_q     <= s1_ang_d;
         s2_valid_q   <= s1_valid_q;
         s2_payload_q <= s2_payload_d;
         overflow_q   <= overflow_d;
      end
   end

   assign fifo_pop   = !fifo_empty && out_ready;
   assign fifo_push  = s2_valid_q && (!fifo_full || fifo_pop);
   assign overflow_d = overflow_q || (s2_valid_q && fifo_full && !fifo_pop);

   sync_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (s2_payload_q),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_unused)
   );

   assign out_valid = !fifo_empty;
   assign out_mag   = fifo_rdata[OUTPUT_WIDTH-1:0];
   assign out_angle = fifo_rdata[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
   assign out_sat   = fifo_rdata[PW-1];
   assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_interface_output.sv
`default_nettype none
// ============================================================================
//  tb_interface_output : directed vectors, FIFO corner sequences and random
//                        traffic against a queue-based reference model
//  Revision            : 1.0
// ============================================================================
module tb_interface_output;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_x, in_z;
   logic [1:0]  in_sector;
   logic        out_valid, out_ready, out_sat, overflow;
   logic [15:0] out_mag, out_angle;

   interface_output #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_z      (in_z),
      .in_sector (in_sector),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mag   (out_mag),
      .out_angle (out_angle),
      .out_sat   (out_sat),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int mag;
      int ang;
      bit sat;
   } exp_t;

   typedef struct {
      int x;
      int z;
      int sec;
      int emag;
      int eang;
      bit esat;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   exp_t q[$];
   bit   s1v, s2v, ovf_m;
   exp_t s1e, s2e;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int rnd_clamp(input longint v, inout bit sat);
      longint s;
      s = (v + 2048) >>> 12;
      if (s > 32767) begin sat = 1; return 32767; end
      if (s < -32768) begin sat = 1; return -32768; end
      return int'(s);
   endfunction

   function automatic exp_t model(input int x, input int z, input int sec);
      longint off[4] = '{0, 1647099, 3294199, -1647099};
      longint m, a;
      exp_t e;
      bit s;
      s     = 0;
      m     = (longint'(x) * 39797) >>> 16;
      a     = longint'(z) + off[sec];
      e.mag = rnd_clamp(m, s);
      e.ang = rnd_clamp(a, s);
      e.sat = s;
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      s1v   = 0;
      s2v   = 0;
      ovf_m = 0;
   endtask

   // One clock: advance the model to what the next edge does, clock the DUT, compare.
   task automatic step(input bit v, input int x, input int z, input int sec, input bit rdy);
      bit pop_m, push_m;
      in_valid  = v;
      in_x      = x;
      in_z      = z;
      in_sector = sec[1:0];
      out_ready = rdy;
      pop_m  = (q.size() != 0) && rdy;
      push_m = s2v && (q.size() < 4 || pop_m);
      if (s2v && !push_m) ovf_m = 1;
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(s2e);
      s2v = s1v;
      s2e = s1e;
      s1v = v;
      s1e = model(x, z, sec);
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("overflow", overflow, ovf_m);
      if (q.size() != 0) begin
         chk("out_mag", $signed(out_mag), q[0].mag);
         chk("out_angle", $signed(out_angle), q[0].ang);
         chk("out_sat", out_sat, q[0].sat);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
   endtask

   vec_t vecs[7];
   int   ovf_exp[4] = '{155, 311, 466, 622};

   initial begin
      vecs[0] = '{1048576, 0, 0, 155, 0, 0};
      vecs[1] = '{0, 0, 1, 0, 402, 0};
      vecs[2] = '{0, 0, 3, 0, -402, 0};
      vecs[3] = '{0, 0, 2, 0, 804, 0};
      vecs[4] = '{2097152000, 0, 0, 32767, 0, 1};
      vecs[5] = '{0, -209715200, 0, 0, -32768, 1};
      vecs[6] = '{-1048576, 0, 0, -155, 0, 0};

      in_x = '0; in_z = '0; in_sector = '0;
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_out_mag", out_mag, 0);
      chk("rst_out_angle", out_angle, 0);
      chk("rst_out_sat", out_sat, 0);

      // Directed vectors: head appears after the third edge.
      foreach (vecs[i]) begin
         step(1, vecs[i].x, vecs[i].z, vecs[i].sec, 1);
         step(0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 1);
         chk("vec_valid", out_valid, 1);
         chk("vec_mag", $signed(out_mag), vecs[i].emag);
         chk("vec_angle", $signed(out_angle), vecs[i].eang);
         chk("vec_sat", out_sat, vecs[i].esat);
         step(0, 0, 0, 0, 1);
      end

      // Overflow: six inputs into a stalled four-entry FIFO.
      do_reset();
      for (int n = 1; n <= 6; n++) step(1, n << 20, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("ovf_flag", overflow, 1);
      for (int n = 0; n < 4; n++) begin
         chk("ovf_order_valid", out_valid, 1);
         chk("ovf_order_mag", $signed(out_mag), ovf_exp[n]);
         step(0, 0, 0, 0, 1);
      end
      chk("ovf_drained", out_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Full FIFO with a pop every cycle absorbs one input per cycle.
      do_reset();
      for (int n = 1; n <= 4; n++) step(1, n << 20, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      for (int n = 0; n < 12; n++) begin
         step(1, (n + 10) << 20, n << 16, n % 4, 1);
         chk("thru_valid", out_valid, 1);
         chk("thru_no_ovf", overflow, 0);
      end
      repeat (8) step(0, 0, 0, 0, 1);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, int'($urandom), int'($urandom) >>> $urandom_range(0, 8),
              $urandom_range(0, 3), $urandom_range(0, 2) != 0);
      end

      // Asynchronous reset between edges with data buffered and overflow set.
      for (int n = 1; n <= 6; n++) step(1, n << 20, 0, 0, 0);
      step(1, 7 << 20, 0, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_overflow", overflow, 0);
      model_reset();
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (6) step(0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
